// File: rtl/hazard_forward_unit.sv
// Operand forwarding, load-use stall FSM and branch-flush control beside ID/EX.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_forward_unit #(
    parameter int unsigned REG_NUMBER = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned LOAD_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*REG_NUMBER-1:0] ID_rs,
    input  logic [NUM_SRC*REG_NUMBER-1:0] ID_EX_rs,
    input  logic                          ID_EX_MemRead,
    input  logic [REG_NUMBER-1:0]         ID_EX_rd,
    input  logic                          EX_MEM_RegWrite,
    input  logic [REG_NUMBER-1:0]         EX_MEM_rd,
    input  logic                          MEM_WB_RegWrite,
    input  logic [REG_NUMBER-1:0]         MEM_WB_rd,
    input  logic                          branch_taken,
    output logic [2*NUM_SRC-1:0]          Forward,
    output logic                          stall,
    output logic                          flush_IF_ID,
    output logic                          flush_ID_EX,
    output logic                          busy,
    output logic [15:0]                   stall_cnt,
    output logic [15:0]                   flush_cnt
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned PERF_W = 16;

    typedef enum logic [0:0] {IDLE, LDSTALL} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*NUM_SRC-1:0] fwd_c;
    logic               lu_hit_c;
    logic               stall_c, flush_if_id_c, flush_id_ex_c;

    // Per-source forwarding select; the youngest producer (EX/MEM) wins, x0 never forwards.
    always_comb begin
        fwd_c = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (EX_MEM_RegWrite && (EX_MEM_rd != '0) &&
                (EX_MEM_rd == ID_EX_rs[i*REG_NUMBER +: REG_NUMBER])) begin
                fwd_c[2*i +: 2] = 2'b10;
            end else if (MEM_WB_RegWrite && (MEM_WB_rd != '0) &&
                         (MEM_WB_rd == ID_EX_rs[i*REG_NUMBER +: REG_NUMBER])) begin
                fwd_c[2*i +: 2] = 2'b01;
            end
        end
    end

    always_comb begin
        lu_hit_c = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (ID_EX_MemRead && (ID_EX_rd != '0) &&
                (ID_EX_rd == ID_rs[i*REG_NUMBER +: REG_NUMBER])) begin
                lu_hit_c = 1'b1;
            end
        end
    end

    // Branch squashes the waiting consumer, so it overrides any pending load stall.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stall_c       = 1'b0;
        flush_if_id_c = 1'b0;
        flush_id_ex_c = 1'b0;
        if (branch_taken) begin
            flush_if_id_c = 1'b1;
            flush_id_ex_c = 1'b1;
            state_d       = IDLE;
            cnt_d         = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lu_hit_c) begin
                        stall_c       = 1'b1;
                        flush_id_ex_c = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = LDSTALL;
                            cnt_d   = CNT_W'(LOAD_LAT - 1);
                        end
                    end
                end
                LDSTALL: begin
                    stall_c       = 1'b1;
                    flush_id_ex_c = 1'b1;
                    cnt_d         = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Controls are gated by reset so they drop the instant rst_n falls.
    assign Forward     = fwd_c;
    assign stall       = stall_c & rst_n;
    assign flush_IF_ID = flush_if_id_c & rst_n;
    assign flush_ID_EX = flush_id_ex_c & rst_n;
    assign busy        = (state_q == LDSTALL) & rst_n;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_c && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
        if (flush_if_id_c && (flush_cnt_q != {PERF_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = PERF_W'(0);
    assign flush_cnt = PERF_W'(0);
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: LOAD_LAT=1 and LOAD_LAT=3 instances share inputs except MemRead.
module tb_hazard_forward_unit;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  fwd;
        logic        s3, fi3, fe3, b3;
        logic        s1, fi1, fe1, b1;
        logic        cc;
        logic [15:0] sc3, fc3, sc1, fc1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  id_rs, id_ex_rs;
    logic        mr1, mr3, exrw, wbrw, br;
    logic [4:0]  idex_rd, exrd, wbrd;
    logic [3:0]  fwd1, fwd3;
    logic        st1, st3, fii1, fii3, fie1, fie3, bz1, bz3;
    logic [15:0] sc1, sc3, fc1, fc3;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_NUMBER(5), .NUM_SRC(2), .LOAD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .ID_rs(id_rs), .ID_EX_rs(id_ex_rs),
        .ID_EX_MemRead(mr1), .ID_EX_rd(idex_rd),
        .EX_MEM_RegWrite(exrw), .EX_MEM_rd(exrd),
        .MEM_WB_RegWrite(wbrw), .MEM_WB_rd(wbrd), .branch_taken(br),
        .Forward(fwd1), .stall(st1), .flush_IF_ID(fii1), .flush_ID_EX(fie1),
        .busy(bz1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    hazard_forward_unit #(.REG_NUMBER(5), .NUM_SRC(2), .LOAD_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .ID_rs(id_rs), .ID_EX_rs(id_ex_rs),
        .ID_EX_MemRead(mr3), .ID_EX_rd(idex_rd),
        .EX_MEM_RegWrite(exrw), .EX_MEM_rd(exrd),
        .MEM_WB_RegWrite(wbrw), .MEM_WB_rd(wbrd), .branch_taken(br),
        .Forward(fwd3), .stall(st3), .flush_IF_ID(fii3), .flush_ID_EX(fie3),
        .busy(bz3), .stall_cnt(sc3), .flush_cnt(fc3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] fwd_model(input logic ew, input logic [4:0] ed,
                                             input logic ww, input logic [4:0] wd,
                                             input logic [9:0] rs);
        logic [3:0] f;
        logic [4:0] r;
        f = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            r = rs[i*5 +: 5];
            if (ew && ed != 5'd0 && ed == r)      f[2*i +: 2] = 2'b10;
            else if (ww && wd != 5'd0 && wd == r) f[2*i +: 2] = 2'b01;
        end
        return f;
    endfunction

    // Queue the expectation for the current input set and advance one cycle.
    task automatic drive(input exp_t x);
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Compare each queued expectation mid-cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t m;
        if (sb.size() > 0) begin
            m = sb.pop_front();
            check("fwd_lat3", 32'(fwd3), 32'(m.fwd));
            check("fwd_lat1", 32'(fwd1), 32'(m.fwd));
            check("stall_lat3", 32'(st3), 32'(m.s3));
            check("flush_if_id_lat3", 32'(fii3), 32'(m.fi3));
            check("flush_id_ex_lat3", 32'(fie3), 32'(m.fe3));
            check("busy_lat3", 32'(bz3), 32'(m.b3));
            check("stall_lat1", 32'(st1), 32'(m.s1));
            check("flush_if_id_lat1", 32'(fii1), 32'(m.fi1));
            check("flush_id_ex_lat1", 32'(fie1), 32'(m.fe1));
            check("busy_lat1", 32'(bz1), 32'(m.b1));
            if (m.cc) begin
                check("stall_cnt_lat3", 32'(sc3), 32'(m.sc3));
                check("flush_cnt_lat3", 32'(fc3), 32'(m.fc3));
                check("stall_cnt_lat1", 32'(sc1), 32'(m.sc1));
                check("flush_cnt_lat1", 32'(fc1), 32'(m.fc1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; id_rs = '0; id_ex_rs = '0; mr1 = 0; mr3 = 0; exrw = 0; wbrw = 0;
        br = 0; idex_rd = '0; exrd = '0; wbrd = '0;
        @(posedge clk); #1;

        // Held in reset: everything quiet, counters zero.
        e = '0; e.cc = 1'b1; drive(e);
        rst_n = 1'b1;

        // EX/MEM beats MEM/WB on both sources.
        exrw = 1; exrd = 5'd5; wbrw = 1; wbrd = 5'd5; id_ex_rs = {5'd5, 5'd5};
        e = '0; e.fwd = 4'b1010; drive(e);

        // x0 never forwarded; src1 picks up MEM/WB.
        exrw = 1; exrd = 5'd0; wbrw = 1; wbrd = 5'd7; id_ex_rs = {5'd7, 5'd0};
        e = '0; e.fwd = 4'b0100; drive(e);

        for (int k = 0; k < 8; k++) begin
            exrw = 1'($urandom_range(0, 1)); wbrw = 1'($urandom_range(0, 1));
            exrd = 5'($urandom_range(0, 3)); wbrd = 5'($urandom_range(0, 3));
            id_ex_rs = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            e = '0; e.fwd = fwd_model(exrw, exrd, wbrw, wbrd, id_ex_rs); drive(e);
        end
        exrw = 0; wbrw = 0; exrd = '0; wbrd = '0; id_ex_rs = '0;

        // Load to x0 is not a hazard.
        mr1 = 1; idex_rd = 5'd0; id_rs = {5'd0, 5'd4};
        e = '0; drive(e);

        // LOAD_LAT=1: single stall cycle, never busy.
        mr1 = 1; idex_rd = 5'd3; id_rs = {5'd3, 5'd0};
        e = '0; e.s1 = 1; e.fe1 = 1; drive(e);
        mr1 = 0;
        e = '0; drive(e);

        // LOAD_LAT=3: three stall cycles, busy in the last two.
        mr3 = 1;
        e = '0; e.s3 = 1; e.fe3 = 1; drive(e);
        e = '0; e.s3 = 1; e.fe3 = 1; e.b3 = 1; drive(e);
        e = '0; e.s3 = 1; e.fe3 = 1; e.b3 = 1; drive(e);
        mr3 = 0;
        e = '0; drive(e);

        // LOAD_LAT=3: branch in second stall cycle abandons the stall.
        mr3 = 1;
        e = '0; e.s3 = 1; e.fe3 = 1; drive(e);
        br = 1;
        e = '0; e.fi3 = 1; e.fe3 = 1; e.b3 = 1; e.fi1 = 1; e.fe1 = 1; drive(e);
        br = 0; mr3 = 0;
        e = '0; e.cc = 1;
        e.sc3 = PERF ? 16'd4 : 16'd0; e.fc3 = PERF ? 16'd1 : 16'd0;
        e.sc1 = PERF ? 16'd1 : 16'd0; e.fc1 = PERF ? 16'd1 : 16'd0;
        drive(e);

        // Reset mid-stall: controls and counters drop at once, forwarding still live.
        mr3 = 1; exrw = 1; exrd = 5'd4; id_ex_rs = {5'd4, 5'd0};
        e = '0; e.fwd = 4'b1000; e.s3 = 1; e.fe3 = 1; drive(e);
        rst_n = 1'b0;
        e = '0; e.fwd = 4'b1000; e.cc = 1; drive(e);
        rst_n = 1'b1; mr3 = 0;
        e = '0; e.fwd = 4'b1000; e.cc = 1; drive(e);

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
